// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding,
// register-index width and the single-operand hazard compare.
package pipe_ctrl_pkg;

  localparam int REG_IND_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // A source operand collides with a destination only when both are live
  // and the index is not x0, which is hard-wired to zero.
  function automatic logic reg_hit(input logic                 src_use,
                                   input logic [REG_IND_W-1:0] src_ind,
                                   input logic                 dst_wr,
                                   input logic [REG_IND_W-1:0] dst_ind);
    return src_use & dst_wr & (src_ind != '0) & (src_ind == dst_ind);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Decode-stage operand compare producing the stall request.
// PIPE_CTRL_FWD_EN defined: only load-use stalls; otherwise any EX/MEM hit stalls.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IND_W-1:0] id_rs1_ind_i,
  input  logic [REG_IND_W-1:0] id_rs2_ind_i,
  input  logic                 id_rs1_use_i,
  input  logic                 id_rs2_use_i,
  input  logic [REG_IND_W-1:0] ex_rd_ind_i,
  input  logic                 ex_wr_en_i,
  input  logic                 ex_is_load_i,
  input  logic [REG_IND_W-1:0] mem_rd_ind_i,
  input  logic                 mem_wr_en_i,
  output logic                 stall_o
);

  logic ex_hit;
  logic load_use;

  assign ex_hit   = reg_hit(id_rs1_use_i, id_rs1_ind_i, ex_wr_en_i, ex_rd_ind_i)
                  | reg_hit(id_rs2_use_i, id_rs2_ind_i, ex_wr_en_i, ex_rd_ind_i);
  assign load_use = ex_is_load_i & ex_hit;

`ifdef PIPE_CTRL_FWD_EN
  // Forwarding covers every ALU result; the MEM-stage destination is unneeded.
  logic unused_mem;
  assign unused_mem = ^{mem_rd_ind_i, mem_wr_en_i};
  assign stall_o    = load_use;
`else
  logic mem_hit;
  assign mem_hit = reg_hit(id_rs1_use_i, id_rs1_ind_i, mem_wr_en_i, mem_rd_ind_i)
                 | reg_hit(id_rs2_use_i, id_rs2_ind_i, mem_wr_en_i, mem_rd_ind_i);
  assign stall_o = load_use | ex_hit | mem_hit;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage enables/flushes, memory-wait FSM with timeout.
// Optional macro PIPE_CTRL_FWD_EN selects forwarding-aware hazard detection.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TO_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IND_W-1:0] id_rs1_ind,
  input  logic [REG_IND_W-1:0] id_rs2_ind,
  input  logic                 id_rs1_use,
  input  logic                 id_rs2_use,
  input  logic [REG_IND_W-1:0] ex_rd_ind,
  input  logic                 ex_wr_en,
  input  logic                 ex_is_load,
  input  logic [REG_IND_W-1:0] mem_rd_ind,
  input  logic                 mem_wr_en,
  input  logic                 ex_jmp_take,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 if_en,
  output logic                 id_en,
  output logic                 ex_en,
  output logic                 mem_en,
  output logic                 wb_en,
  output logic                 id_flush,
  output logic                 ex_flush,
  output logic                 mem_err,
  output logic [1:0]           state
);

  localparam int               CNT_W    = (MEM_TO_CYC > 0) ? $clog2(MEM_TO_CYC + 1) : 1;
  localparam bit               TO_EN    = (MEM_TO_CYC > 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(MEM_TO_CYC - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       en;
  logic             stall;

  hazard_detect u_hazard (
    .id_rs1_ind_i (id_rs1_ind),
    .id_rs2_ind_i (id_rs2_ind),
    .id_rs1_use_i (id_rs1_use),
    .id_rs2_use_i (id_rs2_use),
    .ex_rd_ind_i  (ex_rd_ind),
    .ex_wr_en_i   (ex_wr_en),
    .ex_is_load_i (ex_is_load),
    .mem_rd_ind_i (mem_rd_ind),
    .mem_wr_en_i  (mem_wr_en),
    .stall_o      (stall)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    en       = '0;
    id_flush = 1'b0;
    ex_flush = 1'b0;
    mem_err  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ack) begin
          state_d = MEM_WAIT;
          cnt_d   = '0;
        end else if (ex_jmp_take) begin
          en       = '1;
          id_flush = 1'b1;
          ex_flush = 1'b1;
        end else if (stall) begin
          en       = 5'b00111;
          ex_flush = 1'b1;
        end else begin
          en = '1;
        end
      end
      MEM_WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (mem_ack) begin
          en      = '1;
          state_d = RUN;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          state_d = ERR;
        end
      end
      ERR: mem_err = 1'b1;
      default: state_d = RUN;
    endcase

    // Reset is asynchronous, so the outputs must reflect it without an edge.
    if (rst) begin
      en       = '0;
      id_flush = 1'b1;
      ex_flush = 1'b1;
      mem_err  = 1'b0;
    end
  end

  assign {if_en, id_en, ex_en, mem_en, wb_en} = en;
  assign state = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes model expectations, a
// negedge monitor pops and compares against the DUT outputs.
module tb_pipe_ctrl;

  localparam int TO     = 4;
  localparam int BUDGET = 20000;
  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_ERR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1_ind = '0, id_rs2_ind = '0, ex_rd_ind = '0, mem_rd_ind = '0;
  logic       id_rs1_use = 0, id_rs2_use = 0, ex_wr_en = 0, ex_is_load = 0;
  logic       mem_wr_en = 0, ex_jmp_take = 0, mem_req = 0, mem_ack = 0;
  logic       if_en, id_en, ex_en, mem_en, wb_en, id_flush, ex_flush, mem_err;
  logic [1:0] state;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TO_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_ind(id_rs1_ind), .id_rs2_ind(id_rs2_ind),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .ex_rd_ind(ex_rd_ind), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .mem_rd_ind(mem_rd_ind), .mem_wr_en(mem_wr_en),
    .ex_jmp_take(ex_jmp_take), .mem_req(mem_req), .mem_ack(mem_ack),
    .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
    .id_flush(id_flush), .ex_flush(ex_flush), .mem_err(mem_err), .state(state)
  );

  typedef struct packed {
    logic [4:0] en;     // if, id, ex, mem, wb
    logic       id_f;
    logic       ex_f;
    logic       err;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    exp_t  v;
    string tag;
  } sb_t;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, exrd, memrd;
    logic       u1, u2, exwr, exld, memwr, jmp, req, ack;
  } stim_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  stim_done = 0;

  int  m_mode   = M_RUN;
  int  m_waited = 0;

  function automatic bit hits(logic u, logic [4:0] ind, logic wr, logic [4:0] rd);
    return u && ind != 0 && wr && ind == rd;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 0, rs1: 0, rs2: 0, exrd: 0, memrd: 0, u1: 0, u2: 0,
          exwr: 0, exld: 0, memwr: 0, jmp: 0, req: 0, ack: 0};
    return s;
  endfunction

  function automatic bit wants_stall(stim_t s);
    bit ex_hit, mem_hit;
    ex_hit  = hits(s.u1, s.rs1, s.exwr, s.exrd) || hits(s.u2, s.rs2, s.exwr, s.exrd);
    mem_hit = hits(s.u1, s.rs1, s.memwr, s.memrd) || hits(s.u2, s.rs2, s.memwr, s.memrd);
`ifdef PIPE_CTRL_FWD_EN
    return s.exld && ex_hit;
`else
    return ex_hit || mem_hit;
`endif
  endfunction

  // Applies one cycle of inputs, predicts the outputs and advances the model.
  task automatic drive(input stim_t s, input string tag);
    exp_t e;
    sb_t  item;
    @(posedge clk);
    #1;
    rst = s.rst;
    id_rs1_ind = s.rs1;  id_rs2_ind = s.rs2;
    id_rs1_use = s.u1;   id_rs2_use = s.u2;
    ex_rd_ind = s.exrd;  ex_wr_en = s.exwr;  ex_is_load = s.exld;
    mem_rd_ind = s.memrd; mem_wr_en = s.memwr;
    ex_jmp_take = s.jmp; mem_req = s.req;    mem_ack = s.ack;

    e = '0;
    if (s.rst) begin
      e.id_f = 1; e.ex_f = 1;
      m_mode = M_RUN; m_waited = 0;
    end else if (m_mode == M_ERR) begin
      e.err = 1; e.st = 2'd2;
    end else if (m_mode == M_WAIT) begin
      e.st = 2'd1;
      if (s.ack) begin
        e.en = 5'b11111; m_mode = M_RUN;
      end else begin
        if (TO > 0 && m_waited == TO - 1) m_mode = M_ERR;
        m_waited++;
      end
    end else begin
      if (s.req && !s.ack) begin
        m_mode = M_WAIT; m_waited = 0;
      end else if (s.jmp) begin
        e.en = 5'b11111; e.id_f = 1; e.ex_f = 1;
      end else if (wants_stall(s)) begin
        e.en = 5'b00111; e.ex_f = 1;
      end else begin
        e.en = 5'b11111;
      end
    end
    item.v = e;
    item.tag = tag;
    sb_q.push_back(item);
  endtask

  task automatic run_stimulus();
    stim_t s;
    drive('{rst: 1, default: 0}, "reset");
    drive('{rst: 1, default: 0}, "reset_hold");
    drive(idle(), "post_reset");

    s = idle(); s.exld = 1; s.exwr = 1; s.exrd = 5; s.u1 = 1; s.rs1 = 5;
    drive(s, "load_use");
    drive(idle(), "after_bubble");
    s.exrd = 0; s.rs1 = 0;
    drive(s, "x0_no_hazard");
    s = idle(); s.exld = 1; s.exwr = 1; s.exrd = 9; s.u2 = 1; s.rs2 = 9; s.jmp = 1;
    drive(s, "jmp_over_stall");

    s = idle(); s.req = 1; s.jmp = 1;
    drive(s, "mem_enter");
    s.jmp = 1;
    drive(s, "mem_wait_a");
    drive(s, "mem_wait_b");
    s.ack = 1;
    drive(s, "mem_ack");
    drive(idle(), "mem_back_run");

    s = idle(); s.req = 1;
    for (int i = 0; i < 8; i++) drive(s, "timeout_seq");
    s.jmp = 1;
    drive(s, "err_sticky");
    drive('{rst: 1, default: 0}, "err_reset");
    drive(idle(), "err_cleared");

    s = idle(); s.memwr = 1; s.memrd = 7; s.u2 = 1; s.rs2 = 7;
    for (int i = 0; i < 3; i++) drive(s, "mem_raw_hold");
    s.memrd = 6;
    drive(s, "mem_raw_clear");

    s = idle(); s.req = 1;
    drive(s, "wait_then_rst");
    drive(s, "wait_then_rst");
    drive('{rst: 1, default: 0}, "rst_in_wait");
    drive(idle(), "rst_in_wait_released");

    for (int i = 0; i < 800; i++) begin
      s.rst   = ($urandom_range(0, 99) < 2);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.exrd  = 5'($urandom_range(0, 3));
      s.memrd = 5'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.exwr  = 1'($urandom_range(0, 1));
      s.exld  = 1'($urandom_range(0, 1));
      s.memwr = 1'($urandom_range(0, 1));
      s.jmp   = ($urandom_range(0, 99) < 20);
      s.req   = ($urandom_range(0, 99) < 25);
      s.ack   = ($urandom_range(0, 99) < 30);
      drive(s, "random");
    end
    @(posedge clk);
    stim_done = 1;
  endtask

  task automatic run_monitor();
    exp_t act;
    sb_t  item;
    int   cyc = 0;
    while (!stim_done || sb_q.size() != 0) begin
      @(negedge clk);
      cyc++;
      if (cyc > BUDGET) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout: monitor exceeded %0d cycles, %0d expectations left", BUDGET, sb_q.size());
        break;
      end
      if (sb_q.size() != 0) begin
        item = sb_q.pop_front();
        act  = {if_en, id_en, ex_en, mem_en, wb_en, id_flush, ex_flush, mem_err, state};
        n_checks++;
        if (act !== item.v) begin
          n_fail++;
          $display("FAIL %s @%0t: got en=%b idf=%b exf=%b err=%b st=%0d, want en=%b idf=%b exf=%b err=%b st=%0d",
                   item.tag, $time, act.en, act.id_f, act.ex_f, act.err, act.st,
                   item.v.en, item.v.id_f, item.v.ex_f, item.v.err, item.v.st);
        end
      end
    end
  endtask

  initial begin
    fork
      run_stimulus();
      run_monitor();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
